// File: rtl/mem_access_unit.sv
// Data-memory access unit: formats loads/stores onto a little-endian req/ack bus.
// Stalls the pipeline from request until ack, misalignment or watchdog expiry.
module mem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_read,
  input  logic                    cpu_write,
  input  logic [1:0]              cpu_size,
  input  logic                    cpu_sign_ext,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  input  logic [DATA_WIDTH-1:0]   cpu_wdata,
  input  logic                    if_stall,
  output logic [DATA_WIDTH-1:0]   cpu_rdata,
  output logic                    mem_stall,
  output logic                    addr_err,
  output logic                    bus_err,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic                    mem_re,
  output logic                    mem_we,
  input  logic                    mem_ack,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(NB);
  localparam int WDW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;
  localparam logic [1:0] S_ERR    = 2'd3;

  logic [1:0]            r_state;
  logic                  r_write;
  logic [1:0]            r_size;
  logic                  r_sext;
  logic [OFFW-1:0]       r_offset;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [NB-1:0]         r_be;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_addr_err;
  logic                  r_bus_err;
  logic [WDW-1:0]        r_wdog;

  logic                  w_req;
  logic [OFFW-1:0]       w_offset;
  logic [OFFW-1:0]       w_align_mask;
  logic [2:0]            w_grp_m1;
  logic [NB-1:0]         w_lane_mask;
  logic                  w_size_ok;
  logic                  w_aligned;
  logic [NB-1:0]         w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_shifted;
  logic                  w_msb;
  logic [DATA_WIDTH-1:0] w_load;
  logic                  w_wdog_exp;

  assign w_req     = cpu_read | cpu_write;
  assign w_offset  = cpu_addr[OFFW-1:0];
  assign w_size_ok = (cpu_size != 2'd3) || (DATA_WIDTH == 64);

  always_comb begin
    w_align_mask = '0;
    w_grp_m1     = 3'd0;
    w_lane_mask  = '0;
    case (cpu_size)
      2'd0: begin
        w_align_mask = '0;
        w_grp_m1     = 3'd0;
        w_lane_mask  = NB'(1);
      end
      2'd1: begin
        w_align_mask = OFFW'(1);
        w_grp_m1     = 3'd1;
        w_lane_mask  = NB'(3);
      end
      2'd2: begin
        w_align_mask = OFFW'(3);
        w_grp_m1     = 3'd3;
        w_lane_mask  = NB'(15);
      end
      default: begin
        w_align_mask = OFFW'(7);
        w_grp_m1     = 3'd7;
        w_lane_mask  = '1;
      end
    endcase
  end

  assign w_aligned = w_size_ok && ((w_offset & w_align_mask) == '0);
  assign w_be      = w_lane_mask << w_offset;

  // Each lane takes the byte at its position within the access-size group.
  always_comb begin
    w_wdata = '0;
    for (int i = 0; i < NB; i++) begin
      w_wdata[8*i +: 8] = cpu_wdata[8*(i & int'(w_grp_m1)) +: 8];
    end
  end

  assign w_shifted = mem_rdata >> {r_offset, 3'b000};

  always_comb begin
    w_msb = 1'b0;
    case (r_size)
      2'd0:    w_msb = w_shifted[7];
      2'd1:    w_msb = w_shifted[15];
      2'd2:    w_msb = w_shifted[31];
      default: w_msb = w_shifted[DATA_WIDTH-1];
    endcase
  end

  always_comb begin
    w_load = '0;
    for (int j = 0; j < DATA_WIDTH; j++) begin
      if (j < (8 << r_size)) begin
        w_load[j] = w_shifted[j];
      end else begin
        w_load[j] = r_sext & w_msb;
      end
    end
  end

  assign w_wdog_exp = (TIMEOUT != 0) && (r_wdog == WDW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_write    <= 1'b0;
      r_size     <= 2'd0;
      r_sext     <= 1'b0;
      r_offset   <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_rdata    <= '0;
      r_addr_err <= 1'b0;
      r_bus_err  <= 1'b0;
      r_wdog     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (w_aligned) begin
              r_state  <= S_ACCESS;
              r_write  <= cpu_write;
              r_size   <= cpu_size;
              r_sext   <= cpu_sign_ext;
              r_offset <= w_offset;
              r_addr   <= {cpu_addr[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
              r_wdata  <= w_wdata;
              r_be     <= cpu_write ? w_be : '1;
              r_wdog   <= '0;
            end else begin
              r_state    <= S_ERR;
              r_addr_err <= 1'b1;
            end
          end
        end
        S_ACCESS: begin
          // An ack arriving on the expiry edge still completes the access.
          if (mem_ack) begin
            if (!r_write) begin
              r_rdata <= w_load;
            end
            r_state <= S_DONE;
          end else if (w_wdog_exp) begin
            r_state   <= S_ERR;
            r_bus_err <= 1'b1;
          end else begin
            r_wdog <= r_wdog + WDW'(1);
          end
        end
        default: begin
          if (!if_stall) begin
            r_state    <= S_IDLE;
            r_addr_err <= 1'b0;
            r_bus_err  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign cpu_rdata = r_rdata;
  assign mem_stall = ((r_state == S_IDLE) && w_req) || (r_state == S_ACCESS);
  assign addr_err  = r_addr_err;
  assign bus_err   = r_bus_err;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_be    = r_be;
  assign mem_re    = (r_state == S_ACCESS) && !r_write;
  assign mem_we    = (r_state == S_ACCESS) && r_write;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a 32-bit instance (TIMEOUT=4) and a 64-bit instance.
module tb_mem_access_unit;

  typedef struct {
    logic [63:0] rdata;
    logic        aerr;
    logic        berr;
    logic [7:0]  be;
    logic [63:0] wdata;
    logic [31:0] addr;
    int          req_cyc;
    int          stall_cyc;
    bit          chk_r;
    bit          chk_w;
    logic        we;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [1:0]  rd;
  logic [1:0]  wr;
  logic [1:0]  size;
  logic        sext;
  logic [31:0] addr;
  logic [63:0] wdata;
  logic        if_stall;
  logic [1:0]  ack;
  logic [63:0] rdata_in;

  logic [31:0] d32_rdata, d32_maddr, d32_wdata;
  logic [3:0]  d32_be;
  logic        d32_stall, d32_aerr, d32_berr, d32_re, d32_we;
  logic [63:0] d64_rdata, d64_wdata;
  logic [31:0] d64_maddr;
  logic [7:0]  d64_be;
  logic        d64_stall, d64_aerr, d64_berr, d64_re, d64_we;

  int n_checks = 0;
  int n_err    = 0;

  exp_t q32[$];
  exp_t q64[$];

  int          stall_cnt[2];
  int          req_cnt[2];
  int          txn_no[2];
  logic        prev_st[2];
  logic [7:0]  cap_be[2];
  logic [63:0] cap_wd[2];
  logic [31:0] cap_ad[2];
  logic        cap_we[2];

  mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(4)) u32 (
    .clk(clk), .rst(rst),
    .cpu_read(rd[0]), .cpu_write(wr[0]), .cpu_size(size), .cpu_sign_ext(sext),
    .cpu_addr(addr), .cpu_wdata(wdata[31:0]), .if_stall(if_stall),
    .cpu_rdata(d32_rdata), .mem_stall(d32_stall), .addr_err(d32_aerr), .bus_err(d32_berr),
    .mem_addr(d32_maddr), .mem_wdata(d32_wdata), .mem_be(d32_be),
    .mem_re(d32_re), .mem_we(d32_we), .mem_ack(ack[0]), .mem_rdata(rdata_in[31:0])
  );

  mem_access_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT(255)) u64 (
    .clk(clk), .rst(rst),
    .cpu_read(rd[1]), .cpu_write(wr[1]), .cpu_size(size), .cpu_sign_ext(sext),
    .cpu_addr(addr), .cpu_wdata(wdata), .if_stall(if_stall),
    .cpu_rdata(d64_rdata), .mem_stall(d64_stall), .addr_err(d64_aerr), .bus_err(d64_berr),
    .mem_addr(d64_maddr), .mem_wdata(d64_wdata), .mem_be(d64_be),
    .mem_re(d64_re), .mem_we(d64_we), .mem_ack(ack[1]), .mem_rdata(rdata_in)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] r, input logic ae, input logic be_err,
                              input logic [7:0] be, input logic [63:0] wd, input logic [31:0] ad,
                              input int req, input int st, input bit cr, input bit cw, input logic we);
    exp_t e;
    e.rdata = r; e.aerr = ae; e.berr = be_err; e.be = be; e.wdata = wd; e.addr = ad;
    e.req_cyc = req; e.stall_cyc = st; e.chk_r = cr; e.chk_w = cw; e.we = we;
    return e;
  endfunction

  // Monitor: accumulates per-transaction observations and scores on stall release.
  task automatic mon_step(input int d, input logic stall, input logic re, input logic we,
                          input logic [7:0] be, input logic [63:0] wd, input logic [31:0] ad,
                          input logic [63:0] rdat, input logic aerr, input logic berr);
    exp_t  e;
    bit    empty;
    string p;
    if (!rst) begin
      stall_cnt[d] = 0;
      req_cnt[d]   = 0;
      prev_st[d]   = 1'b0;
      return;
    end
    if (stall) stall_cnt[d]++;
    if (re || we) begin
      if (req_cnt[d] == 0) begin
        cap_be[d] = be; cap_wd[d] = wd; cap_ad[d] = ad; cap_we[d] = we;
      end
      req_cnt[d]++;
    end
    if (prev_st[d] && !stall) begin
      empty = 1'b0;
      if (d == 0) begin
        if (q32.size() == 0) empty = 1'b1; else e = q32.pop_front();
      end else begin
        if (q64.size() == 0) empty = 1'b1; else e = q64.pop_front();
      end
      p = $sformatf("d%0d_t%0d", d, txn_no[d]);
      txn_no[d]++;
      if (empty) begin
        n_checks++;
        n_err++;
        $display("FAIL %s_unexpected: got completion, expected none", p);
      end else begin
        chk({p, "_stall_cycles"}, 64'(stall_cnt[d]), 64'(e.stall_cyc));
        chk({p, "_req_cycles"}, 64'(req_cnt[d]), 64'(e.req_cyc));
        chk({p, "_addr_err"}, {63'b0, aerr}, {63'b0, e.aerr});
        chk({p, "_bus_err"}, {63'b0, berr}, {63'b0, e.berr});
        if (e.chk_r) chk({p, "_rdata"}, rdat, e.rdata);
        if (e.req_cyc > 0) begin
          chk({p, "_be"}, {56'b0, cap_be[d]}, {56'b0, e.be});
          chk({p, "_mem_addr"}, {32'b0, cap_ad[d]}, {32'b0, e.addr});
          chk({p, "_we"}, {63'b0, cap_we[d]}, {63'b0, e.we});
        end
        if (e.chk_w) chk({p, "_wdata"}, cap_wd[d], e.wdata);
      end
      stall_cnt[d] = 0;
      req_cnt[d]   = 0;
    end
    prev_st[d] = stall;
  endtask

  always @(negedge clk) begin
    mon_step(0, d32_stall, d32_re, d32_we, {4'b0, d32_be}, {32'b0, d32_wdata}, d32_maddr,
             {32'b0, d32_rdata}, d32_aerr, d32_berr);
    mon_step(1, d64_stall, d64_re, d64_we, d64_be, d64_wdata, d64_maddr,
             d64_rdata, d64_aerr, d64_berr);
  end

  // One access: request in cycle 0, ack at cycle ack_at (0 = never), then
  // if_stall held for 'hold' cycles with stray requests/acks that must be ignored.
  task automatic txn(input int d, input bit w, input logic [1:0] sz, input bit sx,
                     input logic [31:0] a, input logic [63:0] wd, input int ack_at,
                     input logic [63:0] rv, input int hold, input exp_t e);
    if (d == 0) q32.push_back(e); else q64.push_back(e);
    @(posedge clk); #1;
    rd[d] = !w; wr[d] = w; size = sz; sext = sx; addr = a; wdata = wd;
    for (int c = 1; c <= e.stall_cyc; c++) begin
      @(posedge clk); #1;
      rd[d] = 1'b0; wr[d] = 1'b0;
      ack[d]   = (c == ack_at);
      rdata_in = (c == ack_at) ? rv : 64'h0;
      if (c == e.stall_cyc) if_stall = (hold > 0);
    end
    for (int h = 1; h < hold; h++) begin
      @(posedge clk); #1;
      rd[d] = 1'b1; ack[d] = 1'b1;
    end
    @(posedge clk); #1;
    rd[d] = 1'b0; wr[d] = 1'b0; ack[d] = 1'b0; if_stall = 1'b0; rdata_in = 64'h0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0; rd = 2'b0; wr = 2'b0; size = 2'd0; sext = 1'b0; addr = 32'h0;
    wdata = 64'h0; if_stall = 1'b0; ack = 2'b0; rdata_in = 64'h0;
    txn_no[0] = 0; txn_no[1] = 0;
    #3;
    chk("rst32_rdata", {32'b0, d32_rdata}, 64'h0);
    chk("rst32_ctl", {59'b0, d32_re, d32_we, d32_stall, d32_aerr, d32_berr}, 64'h0);
    chk("rst32_bus", {d32_maddr, d32_wdata}, 64'h0);
    chk("rst32_be", {60'b0, d32_be}, 64'h0);
    chk("rst64_rdata", d64_rdata, 64'h0);
    chk("rst64_ctl", {51'b0, d64_be, d64_re, d64_we, d64_stall, d64_aerr, d64_berr}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // 32-bit instance
    txn(0, 0, 2'd0, 1, 32'h103, 64'h0, 1, 64'h80FF_FFFF, 0,
        mk(64'hFFFF_FF80, 0, 0, 8'hF, 64'h0, 32'h100, 1, 2, 1, 0, 0));
    txn(0, 1, 2'd1, 0, 32'h2, 64'h0000_BEEF, 3, 64'h0, 0,
        mk(64'h0, 0, 0, 8'hC, 64'hBEEF_BEEF, 32'h0, 3, 4, 0, 1, 1));
    txn(0, 0, 2'd2, 0, 32'h6, 64'h0, 0, 64'h0, 2,
        mk(64'h0, 1, 0, 8'h0, 64'h0, 32'h0, 0, 1, 0, 0, 0));
    chk("aerr_cleared", {63'b0, d32_aerr}, 64'h0);
    txn(0, 0, 2'd2, 0, 32'h40, 64'h0, 0, 64'h0, 1,
        mk(64'h0, 0, 1, 8'hF, 64'h0, 32'h40, 4, 5, 0, 0, 0));
    chk("berr_cleared", {63'b0, d32_berr}, 64'h0);
    txn(0, 0, 2'd2, 0, 32'h44, 64'h0, 4, 64'hCAFE_F00D, 0,
        mk(64'hCAFE_F00D, 0, 0, 8'hF, 64'h0, 32'h44, 4, 5, 1, 0, 0));
    txn(0, 0, 2'd1, 1, 32'h102, 64'h0, 1, 64'h8001_1234, 3,
        mk(64'hFFFF_8001, 0, 0, 8'hF, 64'h0, 32'h100, 1, 2, 1, 0, 0));
    txn(0, 0, 2'd0, 0, 32'h101, 64'h0, 2, 64'h0000_A500, 0,
        mk(64'hA5, 0, 0, 8'hF, 64'h0, 32'h100, 2, 3, 1, 0, 0));
    txn(0, 1, 2'd0, 0, 32'h3, 64'h1234_5678, 1, 64'h0, 0,
        mk(64'h0, 0, 0, 8'h8, 64'h7878_7878, 32'h0, 1, 2, 0, 1, 1));
    txn(0, 1, 2'd2, 0, 32'h8, 64'hDEAD_BEEF, 2, 64'h0, 0,
        mk(64'h0, 0, 0, 8'hF, 64'hDEAD_BEEF, 32'h8, 2, 3, 0, 1, 1));
    txn(0, 0, 2'd3, 0, 32'h0, 64'h0, 0, 64'h0, 0,
        mk(64'h0, 1, 0, 8'h0, 64'h0, 32'h0, 0, 1, 0, 0, 0));

    // Reset while a load is outstanding on the 32-bit instance
    @(posedge clk); #1;
    rd[0] = 1'b1; size = 2'd2; addr = 32'h20;
    @(posedge clk); #1;
    rd[0] = 1'b0;
    chk("mid_re_active", {63'b0, d32_re}, 64'h1);
    rst = 1'b0;
    #1;
    chk("mid_re_dropped", {63'b0, d32_re}, 64'h0);
    chk("mid_rdata", {32'b0, d32_rdata}, 64'h0);
    chk("mid_no_err", {62'b0, d32_aerr, d32_berr}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", {62'b0, d32_stall, d32_re}, 64'h0);

    // 64-bit instance
    txn(1, 0, 2'd3, 0, 32'h10, 64'h0, 1, 64'h0123_4567_89AB_CDEF, 0,
        mk(64'h0123_4567_89AB_CDEF, 0, 0, 8'hFF, 64'h0, 32'h10, 1, 2, 1, 0, 0));
    txn(1, 0, 2'd1, 0, 32'h16, 64'h0, 1, 64'h0123_4567_89AB_CDEF, 0,
        mk(64'h0000_0000_0000_0123, 0, 0, 8'hFF, 64'h0, 32'h10, 1, 2, 1, 0, 0));
    txn(1, 0, 2'd2, 1, 32'h1C, 64'h0, 2, 64'h8765_4321_0000_0000, 0,
        mk(64'hFFFF_FFFF_8765_4321, 0, 0, 8'hFF, 64'h0, 32'h18, 2, 3, 1, 0, 0));
    txn(1, 1, 2'd1, 0, 32'hA, 64'h0000_ABCD, 1, 64'h0, 0,
        mk(64'h0, 0, 0, 8'h0C, 64'hABCD_ABCD_ABCD_ABCD, 32'h8, 1, 2, 0, 1, 1));
    txn(1, 1, 2'd3, 0, 32'h18, 64'h1122_3344_5566_7788, 1, 64'h0, 0,
        mk(64'h0, 0, 0, 8'hFF, 64'h1122_3344_5566_7788, 32'h18, 1, 2, 0, 1, 1));
    txn(1, 0, 2'd3, 0, 32'h14, 64'h0, 0, 64'h0, 0,
        mk(64'h0, 1, 0, 8'h0, 64'h0, 32'h0, 0, 1, 0, 0, 0));

    repeat (3) @(posedge clk);
    #1;
    chk("q32_drained", 64'(q32.size()), 64'h0);
    chk("q64_drained", 64'(q64.size()), 64'h0);
    chk("no_stray_req", 64'(req_cnt[0] + req_cnt[1]), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
